spi_adc_responder: RTL and testbench

SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

---
 rtl/spi_pkg.sv | 6 +
 rtl/sync_edge.sv | 25 ++
 rtl/spi_adc_responder.sv | 81 ++++++++
 tb/tb_spi_adc_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and FSM state encoding for the SPI ADC responder
package spi_pkg;
   localparam int WORD_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with one history flop producing rise/fall pulses
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   // shift the asynchronous input through the chain and remember the last synced value
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= (sync_q << 1) | STAGES'(d_i);
         hist_q <= sync_q[STAGES-1];
      end
   end
   assign rise_o = sync_q[STAGES-1] & ~hist_q;
   assign fall_o = ~sync_q[STAGES-1] & hist_q;
endmodule

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 slave that serialises a parallel sample MSB first; optional FRAME_ERR_CHECK_EN flags aborted frames
module spi_adc_responder
   import spi_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] datos,
   input  logic              sck,
   input  logic              sel,
   output logic              miso,
   output logic              siguiente,
   output logic              frame_err
);
   localparam int CW = $clog2(WORD_W);
   logic sck_rise, sck_fall, sel_rise, sel_fall;
   state_t            state_q;
   logic [WORD_W-2:0] shreg_q;
   logic [CW-1:0]     cnt_q;
   logic              miso_q, sig_q;
   sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .rst(rst), .d_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_sel (
      .clk(clk), .rst(rst), .d_i(sel), .rise_o(sel_rise), .fall_o(sel_fall)
   );
   // frame FSM: MSB driven at load, remaining bits advance on sck falls, end of word on the last rise
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         miso_q  <= 1'b0;
         sig_q   <= 1'b0;
      end else begin
         sig_q <= 1'b0;
         if (sel_fall) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (sel_rise) begin
                  shreg_q <= datos[WORD_W-2:0];
                  miso_q  <= datos[WORD_W-1];
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
               SHIFT: if (sck_rise) begin
                  if (cnt_q == CW'(WORD_W-1)) begin
                     sig_q   <= 1'b1;
                     miso_q  <= 1'b0;
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (sck_fall) begin
                  miso_q  <= shreg_q[WORD_W-2];
                  shreg_q <= shreg_q << 1;
               end
               DONE: state_q <= DONE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign miso      = miso_q;
   assign siguiente = sig_q;
`ifdef FRAME_ERR_CHECK_EN
   logic err_q;
   // sticky flag: select withdrawn while bits were still being shifted
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else if (sel_fall && state_q == SHIFT) err_q <= 1'b1;
   end
   assign frame_err = err_q;
`else
   assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: directed SPI master with a scoreboard checking words on each siguiente pulse
module tb_spi_adc_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] datos = 16'h0;
   logic        sck = 1'b0;
   logic        sel = 1'b0;
   logic        miso, siguiente, frame_err;
   logic [31:0] rx;
   logic [15:0] exp_q[$];
   logic        sig_prev = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          sig_count = 0;
   int          s0;
   logic        exp_err;

   spi_adc_responder dut (
      .clk(clk), .rst(rst), .datos(datos), .sck(sck), .sel(sel),
      .miso(miso), .siguiente(siguiente), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every siguiente pulse pops one expected word and compares it with what the master shifted in
   always @(negedge clk) begin
      if (siguiente) begin
         sig_count++;
         chk("sig_width", {31'b0, sig_prev}, 32'h0);
         if (exp_q.size() == 0) chk("sig_unexpected", 32'h1, 32'h0);
         else chk("sb_word", {16'h0, rx[15:0]}, {16'h0, exp_q.pop_front()});
      end
      sig_prev <= siguiente;
   end

   task automatic start_frame(input logic [15:0] d);
      datos = d;
      rx = '0;
      @(negedge clk) sel = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic bits(input int n);
      for (int i = 0; i < n; i++) begin
         rx = {rx[30:0], miso};
         sck = 1'b1;
         repeat (5) @(negedge clk);
         sck = 1'b0;
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic end_frame();
      repeat (5) @(negedge clk);
      sel = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
`ifdef FRAME_ERR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_miso", {31'b0, miso}, 32'h0);
      chk("rst_sig", {31'b0, siguiente}, 32'h0);
      chk("rst_err", {31'b0, frame_err}, 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      // full word A5C3
      s0 = sig_count;
      exp_q.push_back(16'hA5C3);
      start_frame(16'hA5C3);
      chk("load_msb", {31'b0, miso}, 32'h1);
      bits(16);
      chk("a5c3_word", rx, 32'h0000A5C3);
      chk("a5c3_miso_done", {31'b0, miso}, 32'h0);
      end_frame();
      chk("a5c3_sig_once", sig_count - s0, 1);
      // sync latency: next bit appears three clk after the sck fall
      exp_q.push_back(16'h4000);
      start_frame(16'h4000);
      rx = {rx[30:0], miso};
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
      repeat (2) @(negedge clk);
      chk("lat_early", {31'b0, miso}, 32'h0);
      @(negedge clk);
      chk("lat_on_time", {31'b0, miso}, 32'h1);
      repeat (2) @(negedge clk);
      bits(15);
      end_frame();
      // aborted frame after 7 rises
      s0 = sig_count;
      start_frame(16'hFFFF);
      bits(7);
      end_frame();
      chk("abort_miso", {31'b0, miso}, 32'h0);
      chk("abort_no_sig", sig_count - s0, 0);
      chk("abort_err", {31'b0, frame_err}, {31'b0, exp_err});
      // over-clocked frame: extra bits read zero
      s0 = sig_count;
      exp_q.push_back(16'hFFFF);
      start_frame(16'hFFFF);
      bits(16);
      chk("ffff_word", rx, 32'h0000FFFF);
      bits(4);
      chk("ffff_extra_zero", {28'h0, rx[3:0]}, 32'h0);
      end_frame();
      chk("ffff_sig_once", sig_count - s0, 1);
      // datos changes mid-frame
      exp_q.push_back(16'h1234);
      start_frame(16'h1234);
      bits(8);
      datos = 16'h0000;
      bits(8);
      chk("chg_word", rx, 32'h00001234);
      end_frame();
      exp_q.push_back(16'h0000);
      start_frame(16'h0000);
      bits(16);
      chk("next_word", rx, 32'h0);
      end_frame();
      // reset mid-frame after 9 bits
      s0 = sig_count;
      start_frame(16'hFFFF);
      bits(9);
      rst = 1'b1;
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_miso", {31'b0, miso}, 32'h0);
      chk("midrst_sig", {31'b0, siguiente}, 32'h0);
      chk("midrst_err", {31'b0, frame_err}, 32'h0);
      repeat (20) @(negedge clk);
      chk("midrst_no_sig", sig_count - s0, 0);
      exp_q.push_back(16'h8001);
      start_frame(16'h8001);
      bits(16);
      chk("post_rst_word", rx, 32'h00008001);
      end_frame();
      // sck toggling with sel low
      s0 = sig_count;
      datos = 16'hFFFF;
      for (int i = 0; i < 10; i++) begin
         sck = 1'b1;
         repeat (5) @(negedge clk);
         chk("idle_miso", {31'b0, miso}, 32'h0);
         sck = 1'b0;
         repeat (5) @(negedge clk);
      end
      chk("idle_no_sig", sig_count - s0, 0);
      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
